// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared constants and enumerations for the frame buffer access arbiter.
//   FB_AW / FB_DW : default frame buffer address / data widths
//   arb_state_e   : arbiter FSM states (BOOT, RUN, RD_WAIT)
//   requester_e   : write requester identity, used to remember the last grant
// -----------------------------------------------------------------------------
package fb_arb_pkg;

    localparam int FB_AW = 16;
    localparam int FB_DW = 8;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    // Encoding doubles as the bit index into the 2-way req/gnt vectors.
    typedef enum logic {
        LOADER = 1'b0,
        HOST   = 1'b1
    } requester_e;

endpackage

// File: rtl/fb_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_access_arbiter_if
// Bundles the loader, host, renderer and frame buffer signals of the arbiter.
//   slave  modport : arbiter side
//   master modport : environment side (loader, host, renderer, frame buffer)
// Optional macro FB_ARB_STATS_EN adds stat_clr / hs_stall_cnt.
// -----------------------------------------------------------------------------
interface fb_access_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    // loader
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    // host
    logic          hs_valid;
    logic          hs_ready;
    logic          hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic [DW-1:0] hs_rdata;
    logic          hs_rvalid;
    // renderer
    logic          rn_active;
    logic [AW-1:0] rn_addr;
    logic [DW-1:0] rn_data;
    // frame buffer
    logic          fb_we;
    logic [AW-1:0] fb_wa;
    logic [DW-1:0] fb_wd;
    logic [AW-1:0] fb_ra;
    logic [DW-1:0] fb_rd;
`ifdef FB_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   hs_stall_cnt;
`endif

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_done,
        input  hs_valid, hs_we, hs_addr, hs_wdata,
        input  rn_active, rn_addr, fb_rd,
`ifdef FB_ARB_STATS_EN
        input  stat_clr,
        output hs_stall_cnt,
`endif
        output ld_ready, hs_ready, hs_rdata, hs_rvalid, rn_data,
        output fb_we, fb_wa, fb_wd, fb_ra
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_done,
        output hs_valid, hs_we, hs_addr, hs_wdata,
        output rn_active, rn_addr, fb_rd,
`ifdef FB_ARB_STATS_EN
        output stat_clr,
        input  hs_stall_cnt,
`endif
        input  ld_ready, hs_ready, hs_rdata, hs_rvalid, rn_data,
        input  fb_we, fb_wa, fb_wd, fb_ra
    );

endinterface

// File: rtl/fb_rr_pick.sv
// -----------------------------------------------------------------------------
// fb_rr_pick
// Combinational 2-way round-robin grant.
//   req  [1:0] : request vector, bit index = requester_e
//   last       : requester granted most recently
//   gnt  [1:0] : one-hot grant (or zero when nothing requests)
// -----------------------------------------------------------------------------
module fb_rr_pick
    import fb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  requester_e last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            // Contention: the one not served last time wins.
            gnt = (last == HOST) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// fb_access_arbiter
// Shares the frame buffer between the flash loader (writes), the host
// (reads/writes) and the video renderer (reads, absolute priority).
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : fb_access_arbiter_if.slave (loader, host, renderer, fb ports)
// Parameters: AW, DW, BOOT_EXCL (loader exclusive until ld_done).
// Optional macro FB_ARB_STATS_EN adds a saturating host stall counter.
// -----------------------------------------------------------------------------
module fb_access_arbiter
    import fb_arb_pkg::*;
#(
    parameter int AW        = FB_AW,
    parameter int DW        = FB_DW,
    parameter int BOOT_EXCL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_access_arbiter_if.slave   bus
);

    localparam arb_state_e RST_STATE = (BOOT_EXCL != 0) ? BOOT : RUN;

    arb_state_e    r_state;
    requester_e    r_rr_last;
    logic [AW-1:0] r_rd_addr;
    logic          r_fb_we;
    logic [AW-1:0] r_fb_wa;
    logic [DW-1:0] r_fb_wd;
    logic [DW-1:0] r_hs_rdata;
    logic          r_hs_rvalid;

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_ld_ready;
    logic          w_hs_ready;
    logic          w_ld_acc;
    logic          w_hs_wr_acc;
    logic          w_hs_rd_acc;

    // Host writes only compete in RUN; in RD_WAIT the loader still owns
    // the write port on its own.
    assign w_req = {bus.hs_valid & bus.hs_we & (r_state == RUN), bus.ld_valid};

    fb_rr_pick u_rr_pick (
        .req  (w_req),
        .last (r_rr_last),
        .gnt  (w_gnt)
    );

    always_comb begin
        w_ld_ready = 1'b0;
        w_hs_ready = 1'b0;
        case (r_state)
            BOOT:    w_ld_ready = 1'b1;
            RUN: begin
                w_ld_ready = w_gnt[0];
                // Reads use the read port, so they only yield to the renderer.
                w_hs_ready = bus.hs_we ? w_gnt[1] : ~bus.rn_active;
            end
            RD_WAIT: w_ld_ready = w_gnt[0];
            default: ;
        endcase
    end

    assign w_ld_acc    = bus.ld_valid & w_ld_ready;
    assign w_hs_wr_acc = bus.hs_valid &  bus.hs_we & w_hs_ready;
    assign w_hs_rd_acc = bus.hs_valid & ~bus.hs_we & w_hs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RST_STATE;
            r_rr_last   <= HOST;
            r_rd_addr   <= '0;
            r_fb_we     <= 1'b0;
            r_fb_wa     <= '0;
            r_fb_wd     <= '0;
            r_hs_rdata  <= '0;
            r_hs_rvalid <= 1'b0;
        end else begin
            r_fb_we     <= w_ld_acc | w_hs_wr_acc;
            r_hs_rvalid <= 1'b0;
            // Loader and host write grants are mutually exclusive.
            if (w_ld_acc) begin
                r_fb_wa   <= bus.ld_addr;
                r_fb_wd   <= bus.ld_data;
                r_rr_last <= LOADER;
            end else if (w_hs_wr_acc) begin
                r_fb_wa   <= bus.hs_addr;
                r_fb_wd   <= bus.hs_wdata;
                r_rr_last <= HOST;
            end
            case (r_state)
                BOOT: begin
                    if (bus.ld_done) r_state <= RUN;
                end
                RUN: begin
                    if (w_hs_rd_acc) begin
                        r_rd_addr <= bus.hs_addr;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    r_hs_rdata  <= bus.fb_rd;
                    r_hs_rvalid <= 1'b1;
                    r_state     <= RUN;
                end
                default: r_state <= RST_STATE;
            endcase
        end
    end

    // The read port belongs to the renderer except for the single cycle
    // a host read is being sampled.
    assign bus.fb_ra     = (r_state == RD_WAIT) ? r_rd_addr : bus.rn_addr;
    assign bus.rn_data   = bus.fb_rd;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.hs_ready  = w_hs_ready;
    assign bus.hs_rdata  = r_hs_rdata;
    assign bus.hs_rvalid = r_hs_rvalid;
    assign bus.fb_we     = r_fb_we;
    assign bus.fb_wa     = r_fb_wa;
    assign bus.fb_wd     = r_fb_wd;

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (bus.stat_clr) begin
            r_stall_cnt <= '0;
        end else if (bus.hs_valid && !w_hs_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.hs_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_access_arbiter
// Self-checking bench for fb_access_arbiter with a behavioural frame buffer.
// Expected writes / read data are queued when stimulus is driven and compared
// against what the DUT produces. Optional macro FB_ARB_STATS_EN enables the
// stall counter scenario.
// -----------------------------------------------------------------------------
module tb_fb_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fb_access_arbiter_if #(.AW(16), .DW(8)) bus ();

    fb_access_arbiter #(.AW(16), .DW(8), .BOOT_EXCL(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (bus.fb_we) mem[bus.fb_wa] <= bus.fb_wd;
    assign bus.fb_rd = mem[bus.fb_ra];

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_wq[$];
    logic [23:0] obs_wq[$];
    logic [7:0]  exp_rq[$];
    logic [7:0]  obs_rq[$];

    // Advance to the next falling edge and log what the DUT produced.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            if (bus.fb_we) obs_wq.push_back({bus.fb_wa, bus.fb_wd});
            if (bus.hs_rvalid) obs_rq.push_back(bus.hs_rdata);
        end
    endtask

    task automatic idle_inputs();
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.hs_valid = 1'b0; bus.hs_we = 1'b0; bus.hs_addr = '0; bus.hs_wdata = '0;
        bus.rn_active = 1'b0; bus.rn_addr = '0;
`ifdef FB_ARB_STATS_EN
        bus.stat_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.ld_done = 1'b0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        exp_wq.delete(); obs_wq.delete(); exp_rq.delete(); obs_rq.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ld_done = 1'b0;
        bus.ld_valid = 1'b1; bus.hs_valid = 1'b1; bus.hs_we = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL rst_fb_we got %b required 0", bus.fb_we); end
        checks++; if (bus.fb_wa !== 16'h0) begin errors++; $display("FAIL rst_fb_wa got %h required 0000", bus.fb_wa); end
        checks++; if (bus.fb_wd !== 8'h0) begin errors++; $display("FAIL rst_fb_wd got %h required 00", bus.fb_wd); end
        checks++; if (bus.hs_rdata !== 8'h0) begin errors++; $display("FAIL rst_hs_rdata got %h required 00", bus.hs_rdata); end
        checks++; if (bus.hs_rvalid !== 1'b0) begin errors++; $display("FAIL rst_hs_rvalid got %b required 0", bus.hs_rvalid); end
        checks++; if (bus.hs_ready !== 1'b0) begin errors++; $display("FAIL rst_hs_ready got %b required 0", bus.hs_ready); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got %b required 1", bus.ld_ready); end
        $display("reset: state checked");
        do_reset();
    endtask

    task automatic test_boot();
        logic [23:0] ow, ew;
        do_reset();
        bus.hs_valid = 1'b1; bus.hs_we = 1'b1; bus.hs_addr = 16'h0300; bus.hs_wdata = 8'hEE;
        for (int i = 0; i < 11; i++) begin
            bus.ld_valid = 1'b1; bus.ld_addr = 16'h0040 + 16'(i); bus.ld_data = 8'hC0 + 8'(i);
            if (i == 10) bus.ld_done = 1'b1;
            #1;
            checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL boot_ld_ready cyc %0d got %b required 1", i, bus.ld_ready); end
            checks++; if (bus.hs_ready !== 1'b0) begin errors++; $display("FAIL boot_hs_ready cyc %0d got %b required 0", i, bus.hs_ready); end
            exp_wq.push_back({bus.ld_addr, bus.ld_data});
            $display("boot: loader write %h <= %h", bus.ld_addr, bus.ld_data);
            tick();
        end
        // First RUN cycle: loader was served last, so the host wins.
        bus.ld_addr = 16'h004B;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL boot_exit_hs_ready got %b required 1", bus.hs_ready); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL boot_exit_ld_ready got %b required 0", bus.ld_ready); end
        exp_wq.push_back({16'h0300, 8'hEE});
        $display("boot: host write 0300 <= ee after ld_done");
        tick();
        idle_inputs();
        checks++;
        if (obs_wq.size() != exp_wq.size()) begin
            errors++; $display("FAIL boot_wr_count got %0d required %0d", obs_wq.size(), exp_wq.size());
        end
        while (obs_wq.size() > 0 && exp_wq.size() > 0) begin
            ow = obs_wq.pop_front(); ew = exp_wq.pop_front();
            checks++; if (ow !== ew) begin errors++; $display("FAIL boot_wr got %h required %h", ow, ew); end
        end
        obs_wq.delete(); exp_wq.delete();
    endtask

    task automatic test_round_robin();
        logic [23:0] ow, ew;
        int li = 0;
        int hi = 0;
        do_reset();
        bus.ld_done = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            bus.ld_valid = 1'b1; bus.ld_addr = 16'h0100 + 16'(li); bus.ld_data = 8'h10 + 8'(li);
            bus.hs_valid = 1'b1; bus.hs_we = 1'b1;
            bus.hs_addr = 16'h0200 + 16'(hi); bus.hs_wdata = 8'h20 + 8'(hi);
            #1;
            checks++; if (bus.ld_ready !== logic'(c % 2 == 0)) begin errors++; $display("FAIL rr_ld_ready cyc %0d got %b required %b", c, bus.ld_ready, logic'(c % 2 == 0)); end
            checks++; if (bus.hs_ready !== logic'(c % 2 == 1)) begin errors++; $display("FAIL rr_hs_ready cyc %0d got %b required %b", c, bus.hs_ready, logic'(c % 2 == 1)); end
            if (c % 2 == 0) begin
                exp_wq.push_back({bus.ld_addr, bus.ld_data}); li++;
            end else begin
                exp_wq.push_back({bus.hs_addr, bus.hs_wdata}); hi++;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (obs_wq.size() != 8) begin errors++; $display("FAIL rr_wr_count got %0d required 8", obs_wq.size()); end
        while (obs_wq.size() > 0 && exp_wq.size() > 0) begin
            ow = obs_wq.pop_front(); ew = exp_wq.pop_front();
            $display("rr: write %h <= %h", ow[23:8], ow[7:0]);
            checks++; if (ow !== ew) begin errors++; $display("FAIL rr_wr got %h required %h", ow, ew); end
        end
        obs_wq.delete(); exp_wq.delete();
    endtask

    task automatic test_read_latency();
        logic [7:0] orr, er;
        bus.hs_valid = 1'b1; bus.hs_we = 1'b1; bus.hs_addr = 16'h1234; bus.hs_wdata = 8'hA5;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL lat_wr_ready got %b required 1", bus.hs_ready); end
        tick();
        bus.hs_valid = 1'b0;
        tick();
        obs_wq.delete();
        bus.rn_addr = 16'h0777;
        bus.hs_valid = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 16'h1234;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL lat_rd_ready got %b required 1", bus.hs_ready); end
        checks++; if (bus.fb_ra !== 16'h0777) begin errors++; $display("FAIL lat_ra_accept got %h required 0777", bus.fb_ra); end
        exp_rq.push_back(8'hA5);
        tick();
        bus.hs_valid = 1'b0;
        checks++; if (bus.fb_ra !== 16'h1234) begin errors++; $display("FAIL lat_ra_wait got %h required 1234", bus.fb_ra); end
        checks++; if (bus.hs_rvalid !== 1'b0) begin errors++; $display("FAIL lat_rvalid_early got %b required 0", bus.hs_rvalid); end
        tick();
        checks++; if (bus.hs_rvalid !== 1'b1) begin errors++; $display("FAIL lat_rvalid got %b required 1", bus.hs_rvalid); end
        checks++; if (bus.fb_ra !== 16'h0777) begin errors++; $display("FAIL lat_ra_after got %h required 0777", bus.fb_ra); end
        tick();
        checks++; if (bus.hs_rvalid !== 1'b0) begin errors++; $display("FAIL lat_rvalid_pulse got %b required 0", bus.hs_rvalid); end
        checks++;
        if (obs_rq.size() != exp_rq.size()) begin errors++; $display("FAIL lat_rd_count got %0d required %0d", obs_rq.size(), exp_rq.size()); end
        while (obs_rq.size() > 0 && exp_rq.size() > 0) begin
            orr = obs_rq.pop_front(); er = exp_rq.pop_front();
            $display("latency: host read 1234 -> %h", orr);
            checks++; if (orr !== er) begin errors++; $display("FAIL lat_rdata got %h required %h", orr, er); end
        end
        obs_rq.delete(); exp_rq.delete();
    endtask

    task automatic test_renderer();
        logic [7:0] orr, er;
        bus.rn_active = 1'b1; bus.rn_addr = 16'h0000;
        tick(); tick();
        bus.hs_valid = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 16'h1234;
        for (int i = 0; i < 256; i++) begin
            bus.rn_addr = 16'(i);
            #1;
            checks++; if (bus.hs_ready !== 1'b0) begin errors++; $display("FAIL rn_hs_ready addr %0d got %b required 0", i, bus.hs_ready); end
            checks++; if (bus.fb_ra !== 16'(i)) begin errors++; $display("FAIL rn_fb_ra got %h required %h", bus.fb_ra, 16'(i)); end
            tick();
        end
        bus.rn_active = 1'b0;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL rn_release_ready got %b required 1", bus.hs_ready); end
        exp_rq.push_back(8'hA5);
        tick();
        bus.hs_valid = 1'b0;
        tick(); tick();
        checks++;
        if (obs_rq.size() != exp_rq.size()) begin errors++; $display("FAIL rn_rd_count got %0d required %0d", obs_rq.size(), exp_rq.size()); end
        while (obs_rq.size() > 0 && exp_rq.size() > 0) begin
            orr = obs_rq.pop_front(); er = exp_rq.pop_front();
            $display("renderer: deferred host read 1234 -> %h", orr);
            checks++; if (orr !== er) begin errors++; $display("FAIL rn_rdata got %h required %h", orr, er); end
        end
        obs_rq.delete(); exp_rq.delete(); obs_wq.delete();
    endtask

    task automatic test_coherence();
        logic [23:0] ow, ew;
        logic [7:0]  orr, er;
        bus.hs_valid = 1'b1; bus.hs_we = 1'b1; bus.hs_addr = 16'h0010; bus.hs_wdata = 8'h55;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL coh_wr_ready got %b required 1", bus.hs_ready); end
        exp_wq.push_back({16'h0010, 8'h55});
        tick();
        // Host read of the just-written address, loader write in parallel.
        bus.hs_we = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 16'h0011; bus.ld_data = 8'h66;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL coh_rd_ready got %b required 1", bus.hs_ready); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL coh_ld_ready got %b required 1", bus.ld_ready); end
        exp_rq.push_back(8'h55);
        exp_wq.push_back({16'h0011, 8'h66});
        tick();
        bus.ld_valid = 1'b0;
        bus.hs_we = 1'b1; bus.hs_addr = 16'h0020; bus.hs_wdata = 8'h77;
        #1;
        checks++; if (bus.hs_ready !== 1'b0) begin errors++; $display("FAIL coh_rdwait_ready got %b required 0", bus.hs_ready); end
        tick();
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL coh_wr2_ready got %b required 1", bus.hs_ready); end
        exp_wq.push_back({16'h0020, 8'h77});
        tick();
        bus.hs_we = 1'b0; bus.hs_addr = 16'h0011;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL coh_rd2_ready got %b required 1", bus.hs_ready); end
        exp_rq.push_back(8'h66);
        tick();
        bus.hs_valid = 1'b0;
        tick(); tick();
        checks++;
        if (obs_wq.size() != exp_wq.size()) begin errors++; $display("FAIL coh_wr_count got %0d required %0d", obs_wq.size(), exp_wq.size()); end
        while (obs_wq.size() > 0 && exp_wq.size() > 0) begin
            ow = obs_wq.pop_front(); ew = exp_wq.pop_front();
            $display("coherence: write %h <= %h", ow[23:8], ow[7:0]);
            checks++; if (ow !== ew) begin errors++; $display("FAIL coh_wr got %h required %h", ow, ew); end
        end
        checks++;
        if (obs_rq.size() != exp_rq.size()) begin errors++; $display("FAIL coh_rd_count got %0d required %0d", obs_rq.size(), exp_rq.size()); end
        while (obs_rq.size() > 0 && exp_rq.size() > 0) begin
            orr = obs_rq.pop_front(); er = exp_rq.pop_front();
            $display("coherence: host read -> %h", orr);
            checks++; if (orr !== er) begin errors++; $display("FAIL coh_rdata got %h required %h", orr, er); end
        end
        obs_wq.delete(); exp_wq.delete(); obs_rq.delete(); exp_rq.delete();
    endtask

    task automatic test_reset_mid_read();
        bus.ld_valid = 1'b1; bus.ld_addr = 16'h0030; bus.ld_data = 8'h99;
        bus.hs_valid = 1'b1; bus.hs_we = 1'b0; bus.hs_addr = 16'h0010;
        #1;
        checks++; if (bus.hs_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready got %b required 1", bus.hs_ready); end
        tick();
        idle_inputs();
        checks++; if (bus.fb_we !== 1'b1) begin errors++; $display("FAIL mid_fb_we_pre got %b required 1", bus.fb_we); end
        bus.ld_done = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL mid_fb_we got %b required 0", bus.fb_we); end
        checks++; if (bus.hs_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b required 0", bus.hs_rvalid); end
        tick(); tick();
        rst = 1'b1;
        obs_wq.delete(); obs_rq.delete();
        tick(); tick(); tick();
        bus.hs_valid = 1'b1; bus.hs_we = 1'b1;
        #1;
        checks++; if (bus.hs_ready !== 1'b0) begin errors++; $display("FAIL mid_boot_hs_ready got %b required 0", bus.hs_ready); end
        checks++; if (obs_rq.size() != 0) begin errors++; $display("FAIL mid_rvalid_seen got %0d required 0", obs_rq.size()); end
        $display("reset mid-read: read dropped, back in BOOT");
        idle_inputs();
        obs_wq.delete();
    endtask

`ifdef FB_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.hs_valid = 1'b1; bus.hs_we = 1'b1;
        repeat (5) tick();
        checks++; if (bus.hs_stall_cnt !== 16'd5) begin errors++; $display("FAIL stat_cnt got %0d required 5", bus.hs_stall_cnt); end
        bus.stat_clr = 1'b1;
        tick();
        checks++; if (bus.hs_stall_cnt !== 16'd0) begin errors++; $display("FAIL stat_clr got %0d required 0", bus.hs_stall_cnt); end
        bus.stat_clr = 1'b0;
        tick();
        checks++; if (bus.hs_stall_cnt !== 16'd1) begin errors++; $display("FAIL stat_resume got %0d required 1", bus.hs_stall_cnt); end
        $display("stats: stall counter count/clear checked");
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_round_robin();
        test_read_latency();
        test_renderer();
        test_coherence();
        test_reset_mid_read();
`ifdef FB_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
Shares the 64 KiB frame buffer between three requesters: flash loader writes, host read/write accesses, and the video renderer's line-fetch reads.
- Owns the frame buffer's single write port (fb_we/fb_wa/fb_wd) and muxes its single read port (fb_ra/fb_rd).
- Gives the renderer absolute read priority.
- Sits between the loader, the host bus, the renderer and the frame buffer inside gen_video.

Parameters:
AW, 16, frame buffer address width
DW, 8, frame buffer data width
BOOT_EXCL, 1, when 1 the loader has exclusive write access until ld_done

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ld_valid  in  1  loader write request
ld_ready  out  1  loader write accepted this cycle
ld_addr  in  AW  loader write address
ld_data  in  DW  loader write data
ld_done  in  1  level; loader has finished the image
hs_valid  in  1  host request
hs_ready  out  1  host request accepted this cycle
hs_we  in  1  1=write, 0=read
hs_addr  in  AW  host address
hs_wdata  in  DW  host write data
hs_rdata  out  DW  host read data
hs_rvalid  out  1  one-cycle pulse; hs_rdata valid
rn_active  in  1  renderer owns the read port
rn_addr  in  AW  renderer read address
rn_data  out  DW  renderer read data (equals fb_rd)
fb_we  out  1  frame buffer write enable
fb_wa  out  AW  frame buffer write address
fb_wd  out  DW  frame buffer write data
fb_ra  out  AW  frame buffer read address
fb_rd  in  DW  frame buffer read data (combinational from fb_ra)

Behaviour:
- Reset (rst=0, asynchronous):
  - State=BOOT when BOOT_EXCL=1, otherwise RUN.
  - fb_we=0, fb_wa=0, fb_wd=0, hs_rdata=0, hs_rvalid=0, rr_last=HOST.
  - All in-flight operations are dropped.
- States:
  - BOOT: only the loader is served. hs_ready=0. BOOT->RUN on the first clk edge with ld_done=1. No other transition leaves BOOT.
  - RUN: writes are round-robin between loader and host.
  - RD_WAIT: one cycle after a host read is accepted. Always returns to RUN.
- ld_ready/hs_ready are combinational from the current state, valids, rn_active and rr_last. A transfer occurs when valid&&ready at a clk edge.
- Write path: fb_we/fb_wa/fb_wd are registered. Accepted write at edge N appears on the fb_* signals at N+1 and is committed at edge N+1. Latency 1 cycle. At most one write per cycle.
- Round-robin (RUN, both requesting writes): grant the requester not named in rr_last. rr_last updates only on a granted write. A single requester is granted every cycle (no bubbles).
- Host read:
  - Accepted only in RUN, with rn_active=0, hs_we=0, and no write granted to the host this cycle.
  - Loader writes may be accepted in the same cycle, since the write port is independent.
  - On accept: rd_addr_q<=hs_addr; state->RD_WAIT.
  - In RD_WAIT: fb_ra=rd_addr_q; hs_rdata<=fb_rd and hs_rvalid<=1 at the RD_WAIT edge. Accept-to-rvalid = 2 edges.
  - Host writes are not accepted during RD_WAIT; hs_ready=0.
- Read mux: fb_ra = rn_addr except in RD_WAIT. rn_data = fb_rd always.
- Renderer contract: rn_active rises at least 2 cycles before its first valid address. A read already in RD_WAIT completes regardless of rn_active.
- Host read while rn_active=1: hs_ready=0; the request waits with no timeout.
- Same-address write then read (host or loader write at N, host read accepted at N+1): the read returns the new data.
- ld_done falling in RUN has no effect.
- Width rules: addresses are passed unmodified; no wrap or arithmetic.

Optional Feature:
FB_ARB_STATS_EN
- Defined:
  - Adds output port hs_stall_cnt [15:0], a saturating count (sticks at 16'hFFFF) of cycles with hs_valid=1 && hs_ready=0.
  - Adds input stat_clr; stat_clr=1 zeroes the counter synchronously and has priority over increment.
  - Reset value of hs_stall_cnt = 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- fb_arb_pkg:
  - Constants FB_AW=16, FB_DW=8.
  - State enum {BOOT, RUN, RD_WAIT}.
  - Requester enum {LOADER, HOST} used for rr_last.
- Sub-module fb_rr_pick: 2-way round-robin grant logic. Inputs req[1:0] and last. Outputs gnt[1:0]. Purely combinational. The state register stays in the parent.

Test Plan:
- BOOT exclusivity: BOOT_EXCL=1; ld and hs write both valid for 10 cycles; ld_done=0 -> 10 loader writes, fb_we every cycle, hs_ready=0 throughout. Raise ld_done -> next cycle hs granted.
- Round-robin: RUN; ld writes 0x0100..0x0103 and hs writes 0x0200..0x0203, both continuously valid -> fb_wa sequence alternates 0x0100,0x0200,0x0101,0x0201,...; 8 writes in 8 cycles.
- Host read latency: mem[0x1234]=0xA5; hs read 0x1234 with rn_active=0 -> hs_rvalid=1 with hs_rdata=0xA5 exactly 2 edges after accept. fb_ra=0x1234 only in the RD_WAIT cycle.
- Renderer priority: rn_active=1, rn_addr sweeping 0x0000..0x00FF; hs read pending -> hs_ready=0 and fb_ra==rn_addr every cycle. Drop rn_active -> read accepted next cycle.
- Write-then-read coherence: host write 0x55 to 0x0010, then host read 0x0010 issued the following cycle -> hs_rdata=0x55.
- Reset mid-read: assert rst in RD_WAIT -> hs_rvalid stays 0, fb_we=0 immediately, state=BOOT. With FB_ARB_STATS_EN: 5 stall cycles -> hs_stall_cnt=5; stat_clr -> 0.
